// File: rtl/painterengine_gpu_dma_reader.sv
// Single-channel-at-a-time AXI4 read DMA: splits a word-length request into
// bursts that never cross a 1 KB boundary and streams beats to one output lane.
module painterengine_gpu_dma_reader #(
  parameter int unsigned PARAM_TIMEOUT = 65535
) (
  input  logic         i_wire_clock,
  input  logic         i_wire_reset,
  input  logic [3:0]   i_wire_router,
  input  logic [127:0] i_wire_address,
  input  logic [127:0] i_wire_length,
  output logic [127:0] o_wire_data,
  output logic [3:0]   o_wire_data_valid,
  input  logic [3:0]   i_wire_data_ready,
  output logic         o_wire_done,
  output logic         o_wire_error,
  output logic [2:0]   o_wire_error_type,
  output logic [0:0]   o_wire_M_AXI_ARID,
  output logic [31:0]  o_wire_M_AXI_ARADDR,
  output logic [7:0]   o_wire_M_AXI_ARLEN,
  output logic [2:0]   o_wire_M_AXI_ARSIZE,
  output logic [1:0]   o_wire_M_AXI_ARBURST,
  output logic         o_wire_M_AXI_ARLOCK,
  output logic [3:0]   o_wire_M_AXI_ARCACHE,
  output logic [2:0]   o_wire_M_AXI_ARPROT,
  output logic [3:0]   o_wire_M_AXI_ARQOS,
  output logic         o_wire_M_AXI_ARVALID,
  input  logic         i_wire_M_AXI_ARREADY,
  input  logic [0:0]   i_wire_M_AXI_RID,
  input  logic [31:0]  i_wire_M_AXI_RDATA,
  input  logic [1:0]   i_wire_M_AXI_RRESP,
  input  logic         i_wire_M_AXI_RLAST,
  input  logic         i_wire_M_AXI_RVALID,
  output logic         o_wire_M_AXI_RREADY
);

  localparam logic [2:0] ST_ROUTING     = 3'd0;
  localparam logic [2:0] ST_PARAM_CHECK = 3'd1;
  localparam logic [2:0] ST_CALC        = 3'd2;
  localparam logic [2:0] ST_ADDR_READ   = 3'd3;
  localparam logic [2:0] ST_DATA_READ   = 3'd4;
  localparam logic [2:0] ST_DONE        = 3'd5;
  localparam logic [2:0] ST_ERROR       = 3'd6;

  localparam logic [15:0] TIMEOUT_LAST = 16'(PARAM_TIMEOUT - 1);

  logic [2:0]  state;
  logic [1:0]  ch;
  logic [31:0] address;
  logic [31:0] length;
  logic [31:0] offset;
  logic [31:0] remaining;
  logic [8:0]  aligned;
  logic [8:0]  burst_len;
  logic [8:0]  beat_cnt;
  logic [15:0] timeout_cnt;
  logic [2:0]  error_type;
  logic        arvalid;
  logic [31:0] araddr;
  logic [7:0]  arlen;

  logic        route_ok;
  logic [1:0]  route_idx;
  logic [7:0]  word_in_kb;
  logic [8:0]  burst_next;
  logic [31:0] offset_next;
  logic        beat;
  logic        last_beat;
  logic        unused_inputs;

  assign unused_inputs = ^{i_wire_M_AXI_RID, i_wire_M_AXI_RRESP[0]};

  always_comb begin
    route_ok  = 1'b1;
    route_idx = 2'd0;
    case (i_wire_router)
      4'b0001: route_idx = 2'd0;
      4'b0010: route_idx = 2'd1;
      4'b0100: route_idx = 2'd2;
      4'b1000: route_idx = 2'd3;
      default: route_ok = 1'b0;
    endcase
  end

  // Word position inside the current 1 KB page; wraps naturally at 256 words.
  assign word_in_kb  = address[9:2] + offset[7:0];
  assign burst_next  = (remaining < {23'd0, aligned}) ? remaining[8:0] : aligned;
  assign offset_next = offset + {23'd0, burst_len};
  assign beat        = i_wire_M_AXI_RVALID && o_wire_M_AXI_RREADY;
  assign last_beat   = (beat_cnt == burst_len - 9'd1);

  always_ff @(posedge i_wire_clock or posedge i_wire_reset) begin
    if (i_wire_reset) begin
      state       <= ST_ROUTING;
      ch          <= 2'd0;
      address     <= 32'd0;
      length      <= 32'd0;
      offset      <= 32'd0;
      remaining   <= 32'd0;
      aligned     <= 9'd0;
      burst_len   <= 9'd0;
      beat_cnt    <= 9'd0;
      timeout_cnt <= 16'd0;
      error_type  <= 3'd0;
      arvalid     <= 1'b0;
      araddr      <= 32'd0;
      arlen       <= 8'd0;
    end else begin
      case (state)
        ST_ROUTING: begin
          if (i_wire_router != 4'd0) begin
            if (route_ok) begin
              ch      <= route_idx;
              address <= i_wire_address[route_idx*32 +: 32];
              length  <= i_wire_length[route_idx*32 +: 32];
              state   <= ST_PARAM_CHECK;
            end else begin
              error_type <= 3'd1;
              state      <= ST_ERROR;
            end
          end
        end
        ST_PARAM_CHECK: begin
          if (address[1:0] != 2'b00 || length == 32'd0) begin
            error_type <= 3'd2;
            state      <= ST_ERROR;
          end else begin
            offset   <= 32'd0;
            beat_cnt <= 9'd0;
            state    <= ST_CALC;
          end
        end
        ST_CALC: begin
          remaining   <= length - offset;
          aligned     <= 9'd256 - {1'b0, word_in_kb};
          timeout_cnt <= 16'd0;
          state       <= ST_ADDR_READ;
        end
        ST_ADDR_READ: begin
          if (arvalid && i_wire_M_AXI_ARREADY) begin
            arvalid     <= 1'b0;
            beat_cnt    <= 9'd0;
            timeout_cnt <= 16'd0;
            state       <= ST_DATA_READ;
          end else begin
            if (!arvalid) begin
              arvalid   <= 1'b1;
              araddr    <= address + {offset[29:0], 2'b00};
              arlen     <= 8'(burst_next - 9'd1);
              burst_len <= burst_next;
            end
            if (timeout_cnt == TIMEOUT_LAST) begin
              arvalid     <= 1'b0;
              timeout_cnt <= 16'd0;
              error_type  <= 3'd3;
              state       <= ST_ERROR;
            end else begin
              timeout_cnt <= timeout_cnt + 16'd1;
            end
          end
        end
        ST_DATA_READ: begin
          if (beat) begin
            beat_cnt    <= beat_cnt + 9'd1;
            timeout_cnt <= 16'd0;
            if (i_wire_M_AXI_RRESP[1]) begin
              error_type <= 3'd5;
              state      <= ST_ERROR;
            end else if (i_wire_M_AXI_RLAST != last_beat) begin
              error_type <= 3'd6;
              state      <= ST_ERROR;
            end else if (last_beat) begin
              offset <= offset_next;
              state  <= (offset_next >= length) ? ST_DONE : ST_CALC;
            end
          end else if (timeout_cnt == TIMEOUT_LAST) begin
            timeout_cnt <= 16'd0;
            error_type  <= 3'd4;
            state       <= ST_ERROR;
          end else begin
            timeout_cnt <= timeout_cnt + 16'd1;
          end
        end
        default: ;
      endcase
    end
  end

  always_comb begin
    o_wire_data         = '0;
    o_wire_data_valid   = '0;
    o_wire_M_AXI_RREADY = 1'b0;
    if (state == ST_DATA_READ) begin
      o_wire_data[ch*32 +: 32] = i_wire_M_AXI_RDATA;
      o_wire_data_valid[ch]    = i_wire_M_AXI_RVALID;
      o_wire_M_AXI_RREADY      = i_wire_data_ready[ch];
    end
  end

  assign o_wire_done       = (state == ST_DONE);
  assign o_wire_error      = (state == ST_ERROR);
  assign o_wire_error_type = error_type;

  assign o_wire_M_AXI_ARID    = 1'b0;
  assign o_wire_M_AXI_ARADDR  = araddr;
  assign o_wire_M_AXI_ARLEN   = arlen;
  assign o_wire_M_AXI_ARSIZE  = 3'b010;
  assign o_wire_M_AXI_ARBURST = 2'b01;
  assign o_wire_M_AXI_ARLOCK  = 1'b0;
  assign o_wire_M_AXI_ARCACHE = 4'b0010;
  assign o_wire_M_AXI_ARPROT  = 3'b000;
  assign o_wire_M_AXI_ARQOS   = 4'b0000;
  assign o_wire_M_AXI_ARVALID = arvalid;

endmodule

// File: doc/painterengine_gpu_dma_reader.md
PAINTERENGINE_GPU_DMA_READER -- requirements
Module: painterengine_gpu_dma_reader

Interface
REQ-001 Parameter PARAM_TIMEOUT, default 65535, is the number of stall cycles (16-bit) before a timeout error is raised.
REQ-002 i_wire_clock  in  1  the single clock; all state changes on its rising edge.
REQ-003 i_wire_reset  in  1  asynchronous, active-high reset.
REQ-004 i_wire_router  in  4  one-hot channel select; bit n selects channel n.
REQ-005 i_wire_address / i_wire_length  in  128 each  per channel, 32 bits each; channel n occupies bits [n*32+:32]; length is in 32-bit words.
REQ-006 o_wire_data  out  128  read data, lane n = bits [n*32+:32].
REQ-007 o_wire_data_valid  out  4, and i_wire_data_ready  in  4  per-channel consumer handshake.
REQ-008 o_wire_done  out  1; o_wire_error  out  1; o_wire_error_type  out  3.
REQ-009 AXI4 read master: o_wire_M_AXI_ARID[0:0], ARADDR[31:0], ARLEN[7:0], ARSIZE[2:0], ARBURST[1:0], ARLOCK, ARCACHE[3:0], ARPROT[2:0], ARQOS[3:0], ARVALID out; i_wire_M_AXI_ARREADY in; i_wire_M_AXI_RID[0:0], RDATA[31:0], RRESP[1:0], RLAST, RVALID in; o_wire_M_AXI_RREADY out.

Function
REQ-010 Constant outputs: ARID=0, ARSIZE=3'b010, ARBURST=2'b01, ARLOCK=0, ARCACHE=4'b0010, ARPROT=0, ARQOS=0.
REQ-011 States: ROUTING=0, PARAM_CHECK=1, CALC=2, ADDR_READ=3, DATA_READ=4, DONE=5, ERROR=6.
REQ-012 ROUTING: router=0 stays in ROUTING, no timeout count; one-hot value latches channel index, address, length and goes to PARAM_CHECK; any other value goes to ERROR with type 1.
REQ-013 PARAM_CHECK: address[1:0]!=0 or length==0 goes to ERROR with type 2; otherwise clears offset and beat counter and goes to CALC.
REQ-014 CALC, one cycle: remaining = length-offset; aligned = 256-(address[9:2]+offset[7:0]), 9-bit, range 1..256; goes to ADDR_READ.
REQ-015 ADDR_READ: the first cycle registers ARVALID=1, ARADDR=address+offset*4, ARLEN=min(aligned,remaining)-1.
REQ-016 In ADDR_READ, ARADDR and ARLEN SHALL hold stable while ARVALID=1 and ARREADY=0.
REQ-017 A bursts SHALL never cross a 1 KB boundary and SHALL never exceed 256 beats.
REQ-018 On ARVALID&&ARREADY, ARVALID drops the next cycle, the beat counter clears and the state goes to DATA_READ.
REQ-019 In DATA_READ, combinationally: o_wire_data lane ch=RDATA and other lanes 0; o_wire_data_valid[ch]=RVALID; RREADY=i_wire_data_ready[ch]. Outside DATA_READ, RREADY=0 and all valids are 0.
REQ-020 A beat is RVALID&&RREADY and increments the beat counter.
REQ-021 A beat with RRESP>=2'b10 goes to ERROR with type 5.
REQ-022 A beat whose RLAST differs from (counter==burstlen-1) goes to ERROR with type 6; RRESP is checked first.
REQ-023 Last beat of a burst: offset+=burstlen; the next state is DONE if the new offset>=length, otherwise CALC.
REQ-024 Timeout counter (16-bit): increments each ADDR_READ cycle without the AR handshake and each DATA_READ cycle without a beat; clears on progress and on every state change.
REQ-025 Timeout counter reaching PARAM_TIMEOUT goes to ERROR: type 3 in ADDR_READ, type 4 in DATA_READ.
REQ-026 Error types: 0 ok, 1 router, 2 address/length, 3 AR timeout, 4 R timeout, 5 RRESP error, 6 RLAST mismatch.
REQ-027 o_wire_done=(state==DONE) and o_wire_error=(state==ERROR); both states are terminal until reset.
REQ-028 RID is ignored; only one AR transaction is outstanding at any time.

Reset
REQ-029 Reset asserted, including mid-burst, forces on the same edge: state=ROUTING, ARVALID=0, ARADDR=0, ARLEN=0 (burstlen 0), RREADY=0, data_valid=0, done=0, error=0, error_type=0, all counters, offset, address and length = 0.
REQ-030 An abandoned AXI transaction after a reset is the system's responsibility; the block SHALL NOT drain it.

Verification
REQ-031 router=4'b0010, addr1=0x1000_0000, len1=4, ARREADY=1, 4 OKAY beats with RLAST on beat 4 -> one AR at 0x1000_0000 with ARLEN=3; data appears on lane 1 only; done one cycle after beat 4.
REQ-032 addr0=0x1000_03F8, len0=4 -> AR 0x1000_03F8 with ARLEN=1, then AR 0x1000_0400 with ARLEN=1; done after 4 beats total.
REQ-033 addr2=0x1000_0002 -> ERROR with type 2 and ARVALID never asserted; router=4'b0011 -> ERROR with type 1.
REQ-034 RRESP=2'b10 on beat 2 of 4 -> ERROR with type 5; RREADY=0 from the next cycle.
REQ-035 data_ready held 0 with RVALID=1 -> ERROR with type 4 after PARAM_TIMEOUT cycles; RLAST on beat 2 of 4 -> ERROR with type 6.
REQ-036 Reset pulsed while in DATA_READ -> all outputs at REQ-029 values; a new one-hot router then starts a clean transfer.
